ps2_scan_decoder: RTL and testbench

//   Turns the raw PS/2 byte stream from the line receiver into per-key state: a 512-bit
//   key_down map, a 9-bit last_change code and a one-cycle key_valid strobe.

---
 rtl/ps2_scan_decoder_pkg.sv | 59 +++++
 rtl/ps2_scan_decoder_if.sv | 30 +++
 rtl/ps2_scan_decoder_timeout.sv | 48 ++++
 rtl/ps2_scan_decoder.sv | 160 ++++++++++++++++
 tb/tb_ps2_scan_decoder.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_scan_decoder_pkg.sv
// ----------------------------------------------------------------------------
// ps2_scan_decoder_pkg
//   Shared definitions for the PS/2 scan-code decoder:
//     - prefix-tracking FSM state encoding (IDLE / EXT / BRK / EXT_BRK)
//     - prefix byte constants (E0 extended, F0 break)
//     - protocol bytes that carry no key information and are dropped in IDLE
//     - "fake shift" codes (12 / 59) that some keyboards wrap around
//       extended keys and that must not reach the key map
//   Helper functions classify a received byte against those sets.
// ----------------------------------------------------------------------------
package ps2_scan_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // Protocol / status bytes (pause prefix, BAT result, ACK, resend, echo,
    // BAT failure, overrun codes).
    localparam logic [7:0] PS2_IGN_E1 = 8'hE1;
    localparam logic [7:0] PS2_IGN_AA = 8'hAA;
    localparam logic [7:0] PS2_IGN_FA = 8'hFA;
    localparam logic [7:0] PS2_IGN_FE = 8'hFE;
    localparam logic [7:0] PS2_IGN_EE = 8'hEE;
    localparam logic [7:0] PS2_IGN_FC = 8'hFC;
    localparam logic [7:0] PS2_IGN_00 = 8'h00;
    localparam logic [7:0] PS2_IGN_FF = 8'hFF;

    // Left/right shift codes emitted as fake shifts around extended keys.
    localparam logic [7:0] PS2_FAKE_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_FAKE_RSHIFT = 8'h59;

    // True for bytes that are swallowed while no prefix is pending.
    function automatic logic is_ignored(input logic [7:0] b);
        logic r;
        case (b)
            PS2_IGN_E1, PS2_IGN_AA, PS2_IGN_FA, PS2_IGN_FE,
            PS2_IGN_EE, PS2_IGN_FC, PS2_IGN_00, PS2_IGN_FF: r = 1'b1;
            default:                                        r = 1'b0;
        endcase
        return r;
    endfunction

    // True for the shift codes discarded after an E0 prefix.
    function automatic logic is_fake_shift(input logic [7:0] b);
        logic r;
        case (b)
            PS2_FAKE_LSHIFT, PS2_FAKE_RSHIFT: r = 1'b1;
            default:                          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_scan_decoder_if.sv
// ----------------------------------------------------------------------------
// ps2_scan_decoder_if
//   Byte-stream input and key-state output bundle of the scan decoder.
//     rx_byte     8    received scan byte (valid with rx_valid)
//     rx_valid    1    one-cycle byte strobe, no backpressure
//     rx_err      1    parity/framing error on the current byte
//     key_down    512  held-key map indexed by {ext,code}
//     last_change 9    {ext,code} of the latest make/break
//     key_valid   1    one-cycle update strobe
//   master: byte receiver side (drives rx_*, observes key_*)
//   slave : decoder side (observes rx_*, drives key_*)
// ----------------------------------------------------------------------------
interface ps2_scan_decoder_if;
    logic [7:0]   rx_byte;
    logic         rx_valid;
    logic         rx_err;
    logic [511:0] key_down;
    logic [8:0]   last_change;
    logic         key_valid;

    modport master (
        output rx_byte, rx_valid, rx_err,
        input  key_down, last_change, key_valid
    );

    modport slave (
        input  rx_byte, rx_valid, rx_err,
        output key_down, last_change, key_valid
    );
endinterface

// File: rtl/ps2_scan_decoder_timeout.sv
// ----------------------------------------------------------------------------
// ps2_timeout
//   Watchdog for a partially received prefix sequence. The counter advances
//   while run is high and is cleared by clear, by run dropping, and by its own
//   expiry. expire is high while the counter sits at TIMEOUT_CYCLES-1 with
//   run asserted.
//   Ports: clk, rst (async, active-low), run, clear -> expire.
// ----------------------------------------------------------------------------
module ps2_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic expire
);

    localparam int unsigned    TMR_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] timer_d;
    logic [TMR_W-1:0] timer_q;
    logic             expire_s;

    assign expire_s = run && (timer_q == TMR_LAST);
    assign expire   = expire_s;

    // Next counter value: hold at zero unless a prefix is waiting.
    always_comb begin
        timer_d = timer_q;
        if (clear || !run || expire_s) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TMR_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/ps2_scan_decoder.sv
// ----------------------------------------------------------------------------
// ps2_scan_decoder
//   Converts the PS/2 byte stream into per-key state. Tracks the E0 (extended)
//   and F0 (break) prefixes, maintains a 512-entry held-key map indexed by
//   {ext,code}, and reports each make/break through last_change + key_valid.
//   All outputs are registered and change in the cycle after the byte strobe.
//   Ports:
//     clk   system clock
//     rst   asynchronous reset, active-low
//     bus   ps2_scan_decoder_if.slave (rx_* in, key_* out)
//   Build option:
//     TYPEMATIC_FILTER_EN  when defined, a make for a key already held is
//                          absorbed (no map/last_change change, no strobe).
// ----------------------------------------------------------------------------
module ps2_scan_decoder
    import ps2_scan_decoder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    ps2_scan_decoder_if.slave      bus
);

    ps2_state_e   state_d, state_q;
    logic [511:0] key_down_d, key_down_q;
    logic [8:0]   last_change_d, last_change_q;
    logic         key_valid_d, key_valid_q;

    logic [7:0]   rx_byte_s;
    logic         ev_make_s;
    logic         ev_break_s;
    logic [8:0]   code_s;
    logic         expire_s;
    logic         tmr_run_s;

    assign rx_byte_s = bus.rx_byte;
    assign tmr_run_s = (state_q != ST_IDLE);

    // Any strobe (good or bad) restarts the prefix watchdog.
    ps2_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .run    (tmr_run_s),
        .clear  (bus.rx_valid),
        .expire (expire_s)
    );

    // Prefix FSM next state, key event decode and output next values.
    always_comb begin
        state_d       = state_q;
        key_down_d    = key_down_q;
        last_change_d = last_change_q;
        key_valid_d   = 1'b0;
        ev_make_s     = 1'b0;
        ev_break_s    = 1'b0;
        code_s        = 9'h000;

        if (bus.rx_valid && bus.rx_err) begin
            // Corrupt byte: abandon any pending prefix.
            state_d = ST_IDLE;
        end else if (bus.rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_byte_s == PS2_EXT) begin
                        state_d = ST_EXT;
                    end else if (rx_byte_s == PS2_BRK) begin
                        state_d = ST_BRK;
                    end else if (is_ignored(rx_byte_s)) begin
                        state_d = ST_IDLE;
                    end else begin
                        ev_make_s = 1'b1;
                        code_s    = {1'b0, rx_byte_s};
                    end
                end
                ST_EXT: begin
                    if (rx_byte_s == PS2_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else if (rx_byte_s == PS2_EXT) begin
                        state_d = ST_EXT;
                    end else if (is_fake_shift(rx_byte_s)) begin
                        state_d = ST_IDLE;
                    end else begin
                        ev_make_s = 1'b1;
                        code_s    = {1'b1, rx_byte_s};
                        state_d   = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    ev_break_s = 1'b1;
                    code_s     = {1'b0, rx_byte_s};
                    state_d    = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    if (is_fake_shift(rx_byte_s)) begin
                        state_d = ST_IDLE;
                    end else begin
                        ev_break_s = 1'b1;
                        code_s     = {1'b1, rx_byte_s};
                        state_d    = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (expire_s) begin
            // Prefix waited too long for its follow-up byte; drop it silently.
            state_d = ST_IDLE;
        end else begin
            state_d = state_q;
        end

        if (ev_make_s) begin
`ifdef TYPEMATIC_FILTER_EN
            if (key_down_q[code_s]) begin
                // Typematic repeat of a held key: nothing new to report.
                key_valid_d = 1'b0;
            end else begin
                key_down_d[code_s] = 1'b1;
                last_change_d      = code_s;
                key_valid_d        = 1'b1;
            end
`else
            key_down_d[code_s] = 1'b1;
            last_change_d      = code_s;
            key_valid_d        = 1'b1;
`endif
        end else if (ev_break_s) begin
            // Release of a key not held still reports the event.
            key_down_d[code_s] = 1'b0;
            last_change_d      = code_s;
            key_valid_d        = 1'b1;
        end else begin
            key_valid_d = 1'b0;
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            key_down_q    <= 512'd0;
            last_change_q <= 9'h000;
            key_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            key_down_q    <= key_down_d;
            last_change_q <= last_change_d;
            key_valid_q   <= key_valid_d;
        end
    end

    assign bus.key_down    = key_down_q;
    assign bus.last_change = last_change_q;
    assign bus.key_valid   = key_valid_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// ----------------------------------------------------------------------------
// tb_ps2_scan_decoder
//   Self-checking bench for ps2_scan_decoder (TIMEOUT_CYCLES = 16).
//   Reference model: a queue of pending prefix bytes plus a key map, updated
//   once per clock from the byte-level protocol rules.
//   Honours TYPEMATIC_FILTER_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_ps2_scan_decoder;

    localparam int unsigned TMO = 16;

    logic clk;
    logic rst;

    ps2_scan_decoder_if bus();

    ps2_scan_decoder #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;
    int pulse_cnt;

    // ---------------- reference model ----------------
    bit [511:0] m_down;
    bit [8:0]   m_last;
    bit         m_valid;
    bit [7:0]   m_pend[$];
    int         m_gap;

    function automatic bit byte_ignored(input bit [7:0] b);
        return (b == 8'hE1) || (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) ||
               (b == 8'hEE) || (b == 8'hFC) || (b == 8'h00) || (b == 8'hFF);
    endfunction

    function automatic bit byte_fake(input bit [7:0] b);
        return (b == 8'h12) || (b == 8'h59);
    endfunction

    task automatic model_reset();
        m_down  = '0;
        m_last  = 9'h000;
        m_valid = 1'b0;
        m_pend.delete();
        m_gap   = 0;
    endtask

    task automatic model_make(input bit [8:0] k);
`ifdef TYPEMATIC_FILTER_EN
        if (!m_down[k]) begin
            m_down[k] = 1'b1;
            m_last    = k;
            m_valid   = 1'b1;
        end
`else
        m_down[k] = 1'b1;
        m_last    = k;
        m_valid   = 1'b1;
`endif
    endtask

    task automatic model_step(input bit v, input bit [7:0] b, input bit err);
        bit has_e0;
        bit has_f0;
        m_valid = 1'b0;
        has_e0  = 1'b0;
        has_f0  = 1'b0;
        foreach (m_pend[i]) begin
            if (m_pend[i] == 8'hE0) has_e0 = 1'b1;
            if (m_pend[i] == 8'hF0) has_f0 = 1'b1;
        end
        if (v) begin
            m_gap = 0;
            if (err) begin
                m_pend.delete();
            end else if (has_f0) begin
                if (!(has_e0 && byte_fake(b))) begin
                    m_down[{has_e0, b}] = 1'b0;
                    m_last  = {has_e0, b};
                    m_valid = 1'b1;
                end
                m_pend.delete();
            end else if (b == 8'hE0) begin
                if (!has_e0) m_pend.push_back(b);
            end else if (b == 8'hF0) begin
                m_pend.push_back(b);
            end else if (has_e0) begin
                if (!byte_fake(b)) model_make({1'b1, b});
                m_pend.delete();
            end else if (!byte_ignored(b)) begin
                model_make({1'b0, b});
            end
        end else begin
            m_gap++;
            if (m_gap >= TMO) m_pend.delete();
        end
    endtask

    // Drive one clock of stimulus (called at a falling edge), advance the
    // model, and return at the next falling edge with outputs settled.
    task automatic drive(input bit v, input bit [7:0] b, input bit err);
        bus.rx_valid = v;
        bus.rx_byte  = b;
        bus.rx_err   = err;
        model_step(v, b, err);
        @(negedge clk);
        if (bus.key_valid === 1'b1) pulse_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_cmp++;
        if (bus.key_down !== 512'd0) begin
            n_err++; $display("FAIL reset_key_down got %h want 0", bus.key_down);
        end
        n_cmp++;
        if (bus.last_change !== 9'h000) begin
            n_err++; $display("FAIL reset_last_change got %h want 000", bus.last_change);
        end
        n_cmp++;
        if (bus.key_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_key_valid got %b want 0", bus.key_valid);
        end
    endtask

    task automatic test_make();
        int p0;
        p0 = pulse_cnt;
        drive(1'b1, 8'h16, 1'b0);
        n_cmp++;
        if (bus.key_valid !== 1'b1) begin
            n_err++; $display("FAIL make_valid got %b want 1", bus.key_valid);
        end
        n_cmp++;
        if (bus.last_change !== 9'h016) begin
            n_err++; $display("FAIL make_last got %h want 016", bus.last_change);
        end
        n_cmp++;
        if (bus.key_down[9'h016] !== 1'b1) begin
            n_err++; $display("FAIL make_down got %b want 1", bus.key_down[9'h016]);
        end
        idle(1);
        n_cmp++;
        if ((pulse_cnt - p0) !== 1) begin
            n_err++; $display("FAIL make_pulse_width got %0d pulses want 1", pulse_cnt - p0);
        end
    endtask

    task automatic test_break();
        int p0;
        p0 = pulse_cnt;
        drive(1'b1, 8'hF0, 1'b0);
        n_cmp++;
        if (bus.key_valid !== 1'b0) begin
            n_err++; $display("FAIL brk_prefix_valid got %b want 0", bus.key_valid);
        end
        drive(1'b1, 8'h16, 1'b0);
        idle(2);
        n_cmp++;
        if ((pulse_cnt - p0) !== 1) begin
            n_err++; $display("FAIL brk_pulses got %0d want 1", pulse_cnt - p0);
        end
        n_cmp++;
        if (bus.last_change !== 9'h016) begin
            n_err++; $display("FAIL brk_last got %h want 016", bus.last_change);
        end
        n_cmp++;
        if (bus.key_down[9'h016] !== 1'b0) begin
            n_err++; $display("FAIL brk_down got %b want 0", bus.key_down[9'h016]);
        end
    endtask

    task automatic test_extended();
        int p0;
        logic [511:0] snap;
        p0 = pulse_cnt;
        drive(1'b1, 8'hE0, 1'b0);
        drive(1'b1, 8'h70, 1'b0);
        n_cmp++;
        if (bus.key_down[9'h170] !== 1'b1) begin
            n_err++; $display("FAIL ext_make_down got %b want 1", bus.key_down[9'h170]);
        end
        drive(1'b1, 8'hE0, 1'b0);
        drive(1'b1, 8'hF0, 1'b0);
        drive(1'b1, 8'h70, 1'b0);
        idle(1);
        n_cmp++;
        if (bus.key_down[9'h170] !== 1'b0) begin
            n_err++; $display("FAIL ext_brk_down got %b want 0", bus.key_down[9'h170]);
        end
        n_cmp++;
        if ((pulse_cnt - p0) !== 2) begin
            n_err++; $display("FAIL ext_pulses got %0d want 2", pulse_cnt - p0);
        end
        n_cmp++;
        if (bus.last_change !== 9'h170) begin
            n_err++; $display("FAIL ext_last got %h want 170", bus.last_change);
        end
        p0   = pulse_cnt;
        snap = bus.key_down;
        drive(1'b1, 8'hE0, 1'b0);
        drive(1'b1, 8'h12, 1'b0);
        idle(2);
        n_cmp++;
        if ((pulse_cnt - p0) !== 0) begin
            n_err++; $display("FAIL fake_shift_pulses got %0d want 0", pulse_cnt - p0);
        end
        n_cmp++;
        if (bus.key_down !== snap || bus.key_down[9'h112] !== 1'b0) begin
            n_err++; $display("FAIL fake_shift_down got %h want %h", bus.key_down, snap);
        end
    endtask

    task automatic test_timeout_and_error();
        drive(1'b1, 8'hE0, 1'b0);
        idle(20);
        drive(1'b1, 8'h16, 1'b0);
        n_cmp++;
        if (bus.last_change !== 9'h016 || bus.key_down[9'h116] !== 1'b0) begin
            n_err++; $display("FAIL tmo_last got %h want 016", bus.last_change);
        end
        n_cmp++;
        if (bus.key_down[9'h016] !== 1'b1) begin
            n_err++; $display("FAIL tmo_down got %b want 1", bus.key_down[9'h016]);
        end
        drive(1'b1, 8'hF0, 1'b1);
        drive(1'b1, 8'h16, 1'b0);
        idle(1);
        n_cmp++;
        if (bus.last_change !== 9'h016 || bus.key_down[9'h016] !== 1'b1) begin
            n_err++; $display("FAIL err_drop got last %h down %b want 016/1",
                              bus.last_change, bus.key_down[9'h016]);
        end
        // Release so the typematic scenario starts from a clean key.
        drive(1'b1, 8'hF0, 1'b0);
        drive(1'b1, 8'h16, 1'b0);
        idle(1);
        n_cmp++;
        if (bus.key_down[9'h016] !== 1'b0) begin
            n_err++; $display("FAIL err_release got %b want 0", bus.key_down[9'h016]);
        end
    endtask

    task automatic test_back_to_back();
        int p0;
        int exp_p;
`ifdef TYPEMATIC_FILTER_EN
        exp_p = 1;
`else
        exp_p = 3;
`endif
        p0 = pulse_cnt;
        drive(1'b1, 8'h16, 1'b0);
        drive(1'b1, 8'h16, 1'b0);
        drive(1'b1, 8'h16, 1'b0);
        idle(2);
        n_cmp++;
        if ((pulse_cnt - p0) !== exp_p) begin
            n_err++; $display("FAIL typematic_pulses got %0d want %0d", pulse_cnt - p0, exp_p);
        end
        n_cmp++;
        if (bus.key_down[9'h016] !== 1'b1) begin
            n_err++; $display("FAIL typematic_down got %b want 1", bus.key_down[9'h016]);
        end
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 8'hE0, 1'b0);
        bus.rx_valid = 1'b0;
        rst = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (bus.key_down !== 512'd0 || bus.last_change !== 9'h000 || bus.key_valid !== 1'b0) begin
            n_err++; $display("FAIL midrst got down %h last %h valid %b want 0",
                              bus.key_down, bus.last_change, bus.key_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 8'h70, 1'b0);
        n_cmp++;
        if (bus.last_change !== 9'h070 || bus.key_down[9'h070] !== 1'b1 || bus.key_valid !== 1'b1) begin
            n_err++; $display("FAIL midrst_make got last %h down %b valid %b want 070/1/1",
                              bus.last_change, bus.key_down[9'h070], bus.key_valid);
        end
    endtask

    task automatic test_random();
        bit [7:0] b;
        bit       e;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                idle(30);
            end else if ($urandom_range(0, 3) == 0) begin
                drive(1'b0, 8'h00, 1'b0);
            end else begin
                case ($urandom_range(0, 9))
                    0:       b = 8'hE0;
                    1:       b = 8'hF0;
                    2:       b = 8'h16;
                    3:       b = 8'h70;
                    4:       b = 8'h1C;
                    5:       b = byte_fake(8'h12) ? 8'h12 : 8'h59;
                    6:       b = 8'h59;
                    7:       b = 8'hAA;
                    8:       b = 8'h00;
                    default: b = 8'($urandom);
                endcase
                e = ($urandom_range(0, 19) == 0);
                drive(1'b1, b, e);
            end
            n_cmp++;
            if (bus.key_valid !== m_valid) begin
                n_err++; $display("FAIL rnd_valid c=%0d got %b want %b", c, bus.key_valid, m_valid);
            end
            n_cmp++;
            if (bus.last_change !== m_last) begin
                n_err++; $display("FAIL rnd_last c=%0d got %h want %h", c, bus.last_change, m_last);
            end
            n_cmp++;
            if (bus.key_down !== m_down) begin
                n_err++; $display("FAIL rnd_down c=%0d got %h want %h", c, bus.key_down, m_down);
            end
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        pulse_cnt    = 0;
        rst          = 1'b0;
        bus.rx_byte  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.rx_err   = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        test_reset();
        rst = 1'b1;
        @(negedge clk);
        test_make();
        test_break();
        test_extended();
        test_timeout_and_error();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
